dmem_responder: RTL and testbench

- Data-memory responder for the core's load/store path: receives kSTORE/kLOAD requests from the datapath and services them from a private 2^AW x DW array.
- Uses valid/ready handshakes on both request and response, with a fixed configurable wait-state latency.
- Sits between the core's memory stage and the storage array. Only one transaction is outstanding at a time.

---
 rtl/dmem_responder_pkg.sv | 23 ++
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder_array.sv | 24 ++
 rtl/dmem_responder.sv | 146 ++++++++++++++
 tb/tb_dmem_responder.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: op codes, FSM state
// encoding and the default wait-state latency.
package dmem_responder_pkg;

  localparam logic [1:0] kSTORE = 2'b10;
  localparam logic [1:0] kLOAD  = 2'b11;

  localparam int kDMEM_LATENCY = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2,
    INIT = 2'd3
  } dmem_state_t;

  // Only stores and loads reach the array; everything else is answered
  // with an error response.
  function automatic logic is_legal_op(input logic [1:0] op);
    return (op == kSTORE) || (op == kLOAD);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bus between the core memory stage (master) and the
// data-memory responder (slave).
interface dmem_responder_if #(
  parameter int AW = 8,
  parameter int DW = 8
);
  logic          req_valid;
  logic          req_ready;
  logic [1:0]    req_op;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          resp_err;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, resp_ready,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, resp_ready,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

// File: rtl/dmem_responder_array.sv
// Single-port 2^AW x DW storage with synchronous write and registered read.
// No reset on contents or read register so it maps onto block RAM.
module dmem_array #(
  parameter int AW = 8,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic          re_i,
  input  logic [AW-1:0] addr_i,
  input  logic [DW-1:0] wdata_i,
  output logic [DW-1:0] rdata_o
);
  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;

  // Write port and read register; the read word is held until the next read.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts one kSTORE/kLOAD at a time, waits LATENCY
// cycles, accesses the private array and presents a held response.
// Optional build macro DMEM_INIT_EN: reset sweeps the array to zero through
// an INIT state before the first request is accepted.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int AW      = 8,
  parameter int DW      = 8,
  parameter int LATENCY = kDMEM_LATENCY
) (
  input logic Clk,
  input logic Reset,
  dmem_responder_if.slave bus
);

`ifdef DMEM_INIT_EN
  localparam dmem_state_t kRstState = INIT;
  logic [AW-1:0] init_addr_q, init_addr_d;
`else
  localparam dmem_state_t kRstState = IDLE;
`endif

  dmem_state_t   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [1:0]    op_q, op_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          err_q, err_d;

  logic          acc_we, acc_re;
  logic          arr_we;
  logic [AW-1:0] arr_addr;
  logic [DW-1:0] arr_wdata;
  logic [DW-1:0] arr_rdata;

  // State and latched request registers.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= kRstState;
      cnt_q   <= '0;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
    end
  end

`ifdef DMEM_INIT_EN
  // Sweep address counter; restarts at zero on every reset.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) init_addr_q <= '0;
    else       init_addr_q <= init_addr_d;
  end
`endif

  // Next-state logic, handshake outputs and array access strobes.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    op_d           = op_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    err_d          = err_q;
    acc_we         = 1'b0;
    acc_re         = 1'b0;
    bus.req_ready  = 1'b0;
    bus.resp_valid = 1'b0;
`ifdef DMEM_INIT_EN
    init_addr_d    = init_addr_q;
`endif
    case (state_q)
      IDLE: begin
        bus.req_ready = 1'b1;
        if (bus.req_valid) begin
          op_d    = bus.req_op;
          addr_d  = bus.req_addr;
          wdata_d = bus.req_wdata;
          if (is_legal_op(bus.req_op)) begin
            err_d   = 1'b0;
            cnt_d   = 4'(LATENCY - 1);
            state_d = WAIT;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end
      WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          acc_we  = (op_q == kSTORE);
          acc_re  = (op_q == kLOAD);
          state_d = RESP;
        end
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        if (bus.resp_ready) state_d = IDLE;
      end
`ifdef DMEM_INIT_EN
      INIT: begin
        init_addr_d = init_addr_q + 1'b1;
        if (init_addr_q == '1) state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

`ifdef DMEM_INIT_EN
  assign arr_we    = (state_q == INIT) || acc_we;
  assign arr_addr  = (state_q == INIT) ? init_addr_q : addr_q;
  assign arr_wdata = (state_q == INIT) ? '0 : wdata_q;
`else
  assign arr_we    = acc_we;
  assign arr_addr  = addr_q;
  assign arr_wdata = wdata_q;
`endif

  dmem_array #(
    .AW(AW),
    .DW(DW)
  ) u_array (
    .clk    (Clk),
    .we_i   (arr_we),
    .re_i   (acc_re),
    .addr_i (arr_addr),
    .wdata_i(arr_wdata),
    .rdata_o(arr_rdata)
  );

  // Only a load response exposes the array word; the read register is only
  // loaded on the access edge, so the value stays put while RESP stalls.
  assign bus.resp_rdata = (state_q == RESP && op_q == kLOAD) ? arr_rdata : '0;
  assign bus.resp_err   = (state_q == RESP) && err_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: expected responses are queued when a
// request is accepted and compared when the response handshake occurs.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  localparam int AW  = 8;
  localparam int DW  = 8;
  localparam int LAT = 2;
`ifdef DMEM_INIT_EN
  localparam bit kInit = 1'b1;
`else
  localparam bit kInit = 1'b0;
`endif

  typedef struct {
    logic [1:0] op;
    logic [7:0] addr;
    logic [7:0] rdata;
    logic       err;
    int         lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];

  dmem_responder_if #(.AW(AW), .DW(DW)) bus ();

  dmem_responder #(.AW(AW), .DW(DW), .LATENCY(LAT)) dut (
    .Clk  (clk),
    .Reset(rst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Drive one request, wait until it is accepted, queue its expectation.
  task automatic send(input logic [1:0] op, input logic [7:0] addr, input logic [7:0] wdata,
                      input logic [7:0] exp_rdata, input logic exp_err, input bit push);
    int n = 0;
    exp_t e;
    @(negedge clk);
    while (!bus.req_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    if (!bus.req_ready) check("req_ready_timeout", 32'(bus.req_ready), 32'd1);
    bus.req_valid = 1'b1;
    bus.req_op    = op;
    bus.req_addr  = addr;
    bus.req_wdata = wdata;
    e.op    = op;
    e.addr  = addr;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.lat   = exp_err ? 1 : LAT + 1;
    if (push) exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  // Wait for the response (cycles counted from the accept edge), compare it,
  // optionally stall it for 'stall' cycles first, then complete the handshake.
  task automatic recv(input int stall);
    int   n = 0;
    exp_t e;
    logic [7:0] first;
    bus.resp_ready = (stall == 0);
    do begin
      @(negedge clk);
      n++;
    end while (!bus.resp_valid && n < 100);
    if (exp_q.size() == 0) begin
      check("scoreboard_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check("latency", 32'(n), 32'(e.lat));
    check("resp_valid", 32'(bus.resp_valid), 32'd1);
    check("resp_rdata", 32'(bus.resp_rdata), 32'(e.rdata));
    check("resp_err", 32'(bus.resp_err), 32'(e.err));
    $display("txn op=%0b addr=0x%02h rdata=0x%02h err=%0b lat=%0d",
             e.op, e.addr, bus.resp_rdata, bus.resp_err, n);
    if (stall > 0) begin
      first = bus.resp_rdata;
      // A request offered while the responder is busy must be ignored.
      bus.req_valid = 1'b1;
      bus.req_op    = kSTORE;
      bus.req_addr  = e.addr;
      bus.req_wdata = 8'h00;
      for (int i = 0; i < stall; i++) begin
        @(negedge clk);
        check("stall_resp_valid", 32'(bus.resp_valid), 32'd1);
        check("stall_rdata", 32'(bus.resp_rdata), 32'(first));
        check("stall_req_ready", 32'(bus.req_ready), 32'd0);
      end
      bus.req_valid  = 1'b0;
      bus.resp_ready = 1'b1;
      @(negedge clk);
      check("post_resp_valid", 32'(bus.resp_valid), 32'd0);
      check("post_req_ready", 32'(bus.req_ready), 32'd1);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req_ready"}, 32'(bus.req_ready), 32'(!kInit));
    check({tag, "_resp_valid"}, 32'(bus.resp_valid), 32'd0);
    check({tag, "_resp_rdata"}, 32'(bus.resp_rdata), 32'd0);
    check({tag, "_resp_err"}, 32'(bus.resp_err), 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    logic [7:0] a, d;
    bus.req_valid  = 1'b0;
    bus.req_op     = 2'b00;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.resp_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;
    if (kInit) begin
      // Count the cycles spent sweeping the array before the first accept.
      n = 0;
      while (!bus.req_ready && n < 1000) begin
        n++;
        @(negedge clk);
      end
      check("init_cycles", 32'(n), 32'(2 ** AW));
      send(kLOAD, 8'hAB, 8'h00, 8'h00, 1'b0, 1'b1);
      recv(0);
    end

    // Store then load back.
    send(kSTORE, 8'h10, 8'h5A, 8'h00, 1'b0, 1'b1);
    recv(0);
    send(kLOAD, 8'h10, 8'h00, 8'h5A, 1'b0, 1'b1);
    recv(0);

    // Back-pressured load response with a concurrent ignored request.
    send(kLOAD, 8'h10, 8'h00, 8'h5A, 1'b0, 1'b1);
    recv(4);
    send(kLOAD, 8'h10, 8'h00, 8'h5A, 1'b0, 1'b1);
    recv(0);

    // Illegal op: immediate error response, array untouched.
    send(2'b01, 8'h10, 8'hFF, 8'h00, 1'b1, 1'b1);
    recv(0);
    send(2'b00, 8'h10, 8'hFF, 8'h00, 1'b1, 1'b1);
    recv(0);
    send(kLOAD, 8'h10, 8'h00, 8'h5A, 1'b0, 1'b1);
    recv(0);

    // Reset during WAIT drops the pending store.
    send(kSTORE, 8'h20, 8'h11, 8'h00, 1'b0, 1'b1);
    recv(0);
    send(kSTORE, 8'h20, 8'hFF, 8'h00, 1'b0, 1'b0);
    @(negedge clk);
    check("wait_req_ready", 32'(bus.req_ready), 32'd0);
    rst = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(negedge clk);
    rst = 1'b0;
    send(kLOAD, 8'h20, 8'h00, kInit ? 8'h00 : 8'h11, 1'b0, 1'b1);
    recv(0);

    // Top and bottom addresses are distinct words.
    send(kSTORE, 8'hFF, 8'hC3, 8'h00, 1'b0, 1'b1);
    recv(0);
    send(kSTORE, 8'h00, 8'h3C, 8'h00, 1'b0, 1'b1);
    recv(0);
    send(kLOAD, 8'hFF, 8'h00, 8'hC3, 1'b0, 1'b1);
    recv(0);
    send(kLOAD, 8'h00, 8'h00, 8'h3C, 1'b0, 1'b1);
    recv(0);

    // Random store/load pairs on distinct addresses.
    for (int i = 0; i < 6; i++) begin
      a = 8'h40 + 8'(i * 7);
      d = 8'($urandom_range(0, 255));
      send(kSTORE, a, d, 8'h00, 1'b0, 1'b1);
      recv(0);
      send(kLOAD, a, 8'h00, d, 1'b0, 1'b1);
      recv(0);
    end

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
